// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw-input source and the debounce/synchroniser stage.
// The slave side is the debouncer; the master side drives raw_in/clear_glitch.
// fsm_state mirrors the debouncer's qualification state for observation.
interface debounce_sync_if;
   logic       raw_in;
   logic       clear_glitch;
   logic       clean;
   logic       busy;
   logic [7:0] glitch_cnt;
   logic [1:0] fsm_state;

   modport master (
      output raw_in,
      output clear_glitch,
      input  clean,
      input  busy,
      input  glitch_cnt,
      input  fsm_state
   );

   modport slave (
      input  raw_in,
      input  clear_glitch,
      output clean,
      output busy,
      output glitch_cnt,
      output fsm_state
   );
endinterface

// File: rtl/debounce_sync.sv
// Synchroniser plus debounce filter in front of the either-edge detector.
// raw_in is brought into the clk domain through a plain flop chain. A new level
// reaches clean only after STABLE_CYCLES consecutive equal samples. Candidate
// transitions that fall back early are counted in a saturating glitch counter.
// fsm_state encoding: 0 STABLE_LO, 1 WAIT_HI, 2 STABLE_HI, 3 WAIT_LO.
module debounce_sync #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 4,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input logic           clk,
   input logic           rst,
   debounce_sync_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic                   clean_q;
   logic                   busy_q;
   logic [7:0]             glitch_q;
   logic                   glitch_evt;

   // Synchroniser shift register: pure flop chain, no logic between stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A glitch is a WAIT state seeing the old level again before qualification.
   assign glitch_evt = ((state == WAIT_HI) && !s) || ((state == WAIT_LO) && s);

   // Qualification FSM with registered clean/busy and the glitch counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
         cnt      <= '0;
         clean_q  <= INIT_LEVEL;
         busy_q   <= 1'b0;
         glitch_q <= 8'd0;
      end else begin
         case (state)
            STABLE_LO: begin
               if (s) begin
                  state  <= WAIT_HI;
                  cnt    <= CW'(1);
                  busy_q <= 1'b1;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  state  <= STABLE_LO;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_HI;
                  cnt     <= '0;
                  clean_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!s) begin
                  state  <= WAIT_LO;
                  cnt    <= CW'(1);
                  busy_q <= 1'b1;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state  <= STABLE_HI;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_LO;
                  cnt     <= '0;
                  clean_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= STABLE_LO;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase

         // Clear beats a simultaneous glitch; the count saturates at 255.
         if (bus.clear_glitch) begin
            glitch_q <= 8'd0;
         end else if (glitch_evt && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
         end
      end
   end

   assign bus.clean      = clean_q;
   assign bus.busy       = busy_q;
   assign bus.glitch_cnt = glitch_q;
   assign bus.fsm_state  = state;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance plus an INIT_LEVEL=1
// instance, both driven from one linear stimulus sequence.
module tb_debounce_sync;

   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;
   int   ed_cnt = 0;
   int   ed_base;
   logic clean_q = 1'b0;

   debounce_sync_if dif ();
   debounce_sync_if dif1 ();

   debounce_sync u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   debounce_sync #(.INIT_LEVEL(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (dif1.slave)
   );

   // Clock and reference edge detector downstream of clean.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      clean_q <= dif.clean;
      if (dif.clean !== clean_q && !rst) ed_cnt <= ed_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated 2-cycle glitch followed by enough low time to settle.
   task automatic glitch_pulse();
      dif.raw_in = 1'b1;
      step(2);
      dif.raw_in = 1'b0;
      step(4);
   endtask

   initial begin
      rst               = 1'b1;
      dif.raw_in        = 1'b0;
      dif.clear_glitch  = 1'b0;
      dif1.raw_in       = 1'b1;
      dif1.clear_glitch = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);

      // Reset state
      chk("rst_clean", dif.clean, 0);
      chk("rst_busy", dif.busy, 0);
      chk("rst_glitch", dif.glitch_cnt, 0);
      chk("rst_state", dif.fsm_state, 0);
      chk("rst_clean_init1", dif1.clean, 1);
      chk("rst_state_init1", dif1.fsm_state, 2);

      // Clean rising step: raw set before edge E
      dif.raw_in = 1'b1;
      step(2);
      chk("rise_busy_e1", dif.busy, 0);
      step(1);
      chk("rise_busy_e2", dif.busy, 1);
      chk("rise_state_e2", dif.fsm_state, 1);
      step(2);
      chk("rise_clean_e4", dif.clean, 0);
      chk("rise_busy_e4", dif.busy, 1);
      step(1);
      chk("rise_clean_e5", dif.clean, 1);
      chk("rise_busy_e5", dif.busy, 0);
      chk("rise_glitch", dif.glitch_cnt, 0);

      // Clean falling step back to low
      dif.raw_in = 1'b0;
      step(3);
      chk("fall_busy_e2", dif.busy, 1);
      step(2);
      chk("fall_clean_e4", dif.clean, 1);
      step(1);
      chk("fall_clean_e5", dif.clean, 0);
      chk("fall_busy_e5", dif.busy, 0);
      chk("fall_glitch", dif.glitch_cnt, 0);
      step(2);

      // Short glitch: high for exactly 2 cycles
      dif.raw_in = 1'b1;
      step(2);
      dif.raw_in = 1'b0;
      step(1);
      chk("short_busy_e2", dif.busy, 1);
      step(1);
      chk("short_busy_e3", dif.busy, 1);
      step(1);
      chk("short_busy_e4", dif.busy, 0);
      chk("short_clean", dif.clean, 0);
      chk("short_glitch", dif.glitch_cnt, 1);
      step(3);

      // Bounce 1,0,1,0,1 then held 1
      ed_base = ed_cnt;
      dif.raw_in = 1'b1; step(1);
      dif.raw_in = 1'b0; step(1);
      dif.raw_in = 1'b1; step(1);
      dif.raw_in = 1'b0; step(1);
      dif.raw_in = 1'b1; step(1);
      step(4);
      chk("bounce_clean_e8", dif.clean, 0);
      chk("bounce_glitch", dif.glitch_cnt, 3);
      chk("bounce_busy_e8", dif.busy, 1);
      step(1);
      chk("bounce_clean_e9", dif.clean, 1);
      step(3);
      chk("bounce_ed_pulses", ed_cnt - ed_base, 1);

      // Standalone clear
      dif.clear_glitch = 1'b1;
      step(1);
      dif.clear_glitch = 1'b0;
      chk("clear_alone", dif.glitch_cnt, 0);

      // Return low without glitches
      dif.raw_in = 1'b0;
      step(8);
      chk("settle_low_clean", dif.clean, 0);
      chk("settle_low_glitch", dif.glitch_cnt, 0);

      // Saturation: 300 isolated glitches
      for (int i = 0; i < 300; i++) begin
         glitch_pulse();
         if (i == 253) chk("sat_254", dif.glitch_cnt, 254);
      end
      chk("sat_255", dif.glitch_cnt, 255);
      chk("sat_clean", dif.clean, 0);

      // Clear coincident with a glitch event: clear wins
      dif.raw_in = 1'b1;
      step(2);
      dif.raw_in = 1'b0;
      step(2);
      chk("coinc_busy_pre", dif.busy, 1);
      dif.clear_glitch = 1'b1;
      step(1);
      dif.clear_glitch = 1'b0;
      chk("coinc_clear", dif.glitch_cnt, 0);
      chk("coinc_busy", dif.busy, 0);
      step(3);
      chk("coinc_after", dif.glitch_cnt, 0);

      // Reset mid-qualification
      dif.raw_in = 1'b1;
      step(3);
      chk("midrst_busy_pre", dif.busy, 1);
      rst = 1'b1;
      step(1);
      chk("midrst_clean", dif.clean, 0);
      chk("midrst_busy", dif.busy, 0);
      chk("midrst_glitch", dif.glitch_cnt, 0);
      chk("midrst_state", dif.fsm_state, 0);
      rst = 1'b0;
      dif.raw_in = 1'b0;
      step(6);
      chk("midrst_glitch_after", dif.glitch_cnt, 0);
      chk("midrst_clean_after", dif.clean, 0);

      // INIT_LEVEL=1 instance: 1->0 step
      chk("init1_clean_pre", dif1.clean, 1);
      dif1.raw_in = 1'b0;
      step(3);
      chk("init1_busy_e2", dif1.busy, 1);
      step(2);
      chk("init1_clean_e4", dif1.clean, 1);
      step(1);
      chk("init1_clean_e5", dif1.clean, 0);
      chk("init1_busy_e5", dif1.busy, 0);
      chk("init1_glitch", dif1.glitch_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
